// File: rtl/inst_fetch_queue_if.sv
// Fetch-queue bus: PC redirect, IF/ID dequeue and the program-load port.
// master = PC logic / consumer side, slave = the fetch queue.
`ifndef WORD
`define WORD 32
`endif
`ifndef INST_SIZE
`define INST_SIZE 32
`endif

interface inst_fetch_queue_if #(
    parameter int DEPTH = 4
);
    logic                           redirect_valid;
    logic [`WORD-1:0]               redirect_pc;
    logic                           deq_ready;
    logic                           inst_valid;
    logic [`INST_SIZE-1:0]          inst;
    logic [`WORD-1:0]               inst_pc;
    logic                           inst_fault;
    logic [$clog2(DEPTH+1)-1:0]     count;
    logic                           ld_en;
    logic [`WORD-1:0]               ld_addr;
    logic [`INST_SIZE-1:0]          ld_data;

    modport master (
        output redirect_valid, redirect_pc, deq_ready, ld_en, ld_addr, ld_data,
        input  inst_valid, inst, inst_pc, inst_fault, count
    );

    modport slave (
        input  redirect_valid, redirect_pc, deq_ready, ld_en, ld_addr, ld_data,
        output inst_valid, inst, inst_pc, inst_fault, count
    );
endinterface

// File: rtl/inst_fetch_queue.sv
// Instruction memory with registered read, load port and a prefetch queue.
// Pipeline: issue (mem read + s1 tag) -> pend (read data) -> queue entry.
`ifndef WORD
`define WORD 32
`endif
`ifndef INST_SIZE
`define INST_SIZE 32
`endif
`ifndef TEST_INST_FILE
`define TEST_INST_FILE ""
`endif

module inst_fetch_queue #(
    parameter string         PATH     = `TEST_INST_FILE,
    parameter int            SIZE     = 1024,
    parameter int            DEPTH    = 4,
    parameter logic [`WORD-1:0] RESET_PC = '0
) (
    input logic clk,
    input logic rst,
    inst_fetch_queue_if.slave bus
);
    localparam int AW = $clog2(SIZE);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [`INST_SIZE-1:0] mem [SIZE];

    logic [`WORD-1:0]      fetch_pc;
    logic                  halted;
    logic                  s1_valid, s1_fault;
    logic [`WORD-1:0]      s1_pc;
    logic [`INST_SIZE-1:0] rd_data;
    logic                  pend_valid, pend_fault;
    logic [`WORD-1:0]      pend_pc;
    logic [`INST_SIZE-1:0] pend_inst;

    logic [`INST_SIZE-1:0] q_inst  [DEPTH];
    logic [`WORD-1:0]      q_pc    [DEPTH];
    logic                  q_fault [DEPTH];
    logic [PW-1:0]         rd_ptr, wr_ptr;
    logic [CW-1:0]         cnt;

    logic          deq_fire, issue, fetch_fault, ld_in_range;
    logic [CW:0]   occ;

    assign deq_fire    = (cnt != '0) && bus.deq_ready;
    assign fetch_fault = (fetch_pc[1:0] != 2'b00) || (fetch_pc[`WORD-1:AW+2] != '0);
    assign ld_in_range = (bus.ld_addr[`WORD-1:AW+2] == '0);

    // Both in-flight stages reserve a slot, so a full queue can never be overrun.
    assign occ   = {1'b0, cnt} + {{CW{1'b0}}, s1_valid} + {{CW{1'b0}}, pend_valid}
                 - {{CW{1'b0}}, deq_fire};
    assign issue = !halted && !bus.redirect_valid && (occ < (CW+1)'(DEPTH));

    // Memory is never reset; read-first on a same-word load.
    always_ff @(posedge clk) begin
        if (bus.ld_en && ld_in_range) mem[bus.ld_addr[AW+1:2]] <= bus.ld_data;
        if (issue && !fetch_fault)    rd_data <= mem[fetch_pc[AW+1:2]];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc   <= RESET_PC;
            halted     <= 1'b0;
            s1_valid   <= 1'b0;
            s1_fault   <= 1'b0;
            s1_pc      <= '0;
            pend_valid <= 1'b0;
            pend_fault <= 1'b0;
            pend_pc    <= '0;
            pend_inst  <= '0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            cnt        <= '0;
        end else if (bus.redirect_valid) begin
            fetch_pc   <= bus.redirect_pc;
            halted     <= 1'b0;
            s1_valid   <= 1'b0;
            pend_valid <= 1'b0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            cnt        <= '0;
        end else begin
            s1_valid <= issue;
            if (issue) begin
                s1_pc    <= fetch_pc;
                s1_fault <= fetch_fault;
                fetch_pc <= fetch_pc + `WORD'(4);
                if (fetch_fault) halted <= 1'b1;
            end
            pend_valid <= s1_valid;
            if (s1_valid) begin
                pend_pc    <= s1_pc;
                pend_fault <= s1_fault;
                pend_inst  <= s1_fault ? '0 : rd_data;
            end
            if (pend_valid) wr_ptr <= wr_ptr + PW'(1);
            if (deq_fire)   rd_ptr <= rd_ptr + PW'(1);
            cnt <= cnt + {{(CW-1){1'b0}}, pend_valid} - {{(CW-1){1'b0}}, deq_fire};
        end
    end

    always_ff @(posedge clk) begin
        if (pend_valid) begin
            q_inst[wr_ptr]  <= pend_inst;
            q_pc[wr_ptr]    <= pend_pc;
            q_fault[wr_ptr] <= pend_fault;
        end
    end

    assign bus.inst_valid = (cnt != '0);
    assign bus.inst       = bus.inst_valid ? q_inst[rd_ptr]  : '0;
    assign bus.inst_pc    = bus.inst_valid ? q_pc[rd_ptr]    : '0;
    assign bus.inst_fault = bus.inst_valid ? q_fault[rd_ptr] : 1'b0;
    assign bus.count      = cnt;

    logic unused_ld_lsb;
    assign unused_ld_lsb = ^bus.ld_addr[1:0];
endmodule

// File: tb/tb_inst_fetch_queue.sv
// Directed vector bench for inst_fetch_queue (SIZE=1024, DEPTH=4, RESET_PC=0).
module tb_inst_fetch_queue;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    inst_fetch_queue_if #(.DEPTH(4)) bus();

    inst_fetch_queue #(.PATH(""), .SIZE(1024), .DEPTH(4), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    typedef struct {
        logic        r, rv;
        logic [31:0] rpc;
        logic        dq, le;
        logic [31:0] la, ldd;
        logic        ev;
        logic [31:0] ei, ep;
        logic        ef;
        logic [2:0]  ec;
    } vec_t;

    vec_t tbl[$];
    int nvec = 0;
    int nfail = 0;

    // Preloaded word at byte address a.
    function automatic logic [31:0] w(input logic [31:0] a);
        return 32'hA000_0000 | a;
    endfunction

    task automatic add(input logic r, rv, input logic [31:0] rpc, input logic dq, le,
                       input logic [31:0] la, ldd, input logic ev,
                       input logic [31:0] ei, ep, input logic ef, input logic [2:0] ec);
        vec_t v;
        v.r = r; v.rv = rv; v.rpc = rpc; v.dq = dq; v.le = le; v.la = la; v.ldd = ldd;
        v.ev = ev; v.ei = ei; v.ep = ep; v.ef = ef; v.ec = ec;
        tbl.push_back(v);
    endtask

    // Cycle with only deq_ready driven, expecting an empty head.
    task automatic idle(input logic dq);
        add(0, 0, 0, dq, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic head(input logic dq, input logic [31:0] ei, ep, input logic ef,
                        input logic [2:0] ec);
        add(0, 0, 0, dq, 0, 0, 0, 1, ei, ep, ef, ec);
    endtask

    task automatic redir(input logic [31:0] pc, input logic dq);
        add(0, 1, pc, dq, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic ev, input logic [31:0] ei, ep,
                       input logic ef, input logic [2:0] ec);
        nvec++;
        if (bus.inst_valid !== ev || bus.inst !== ei || bus.inst_pc !== ep ||
            bus.inst_fault !== ef || bus.count !== ec) begin
            nfail++;
            $display("FAIL %s: got v=%0b inst=%h pc=%h f=%0b cnt=%0d, want v=%0b inst=%h pc=%h f=%0b cnt=%0d",
                     name, bus.inst_valid, bus.inst, bus.inst_pc, bus.inst_fault, bus.count,
                     ev, ei, ep, ef, ec);
        end
    endtask

    initial begin
        bus.redirect_valid = 0; bus.redirect_pc = 0; bus.deq_ready = 0;
        bus.ld_en = 0; bus.ld_addr = 0; bus.ld_data = 0;

        // Streaming from reset, deq_ready high
        add(1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(1); idle(1);
        head(1, w(0), 32'h0, 0, 1);
        head(1, w(4), 32'h4, 0, 1);
        head(1, w(8), 32'h8, 0, 1);
        head(1, w(12), 32'hC, 0, 1);
        // Backpressure: fill to DEPTH, then drain in order
        add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(0); idle(0);
        head(0, w(0), 0, 0, 1); head(0, w(0), 0, 0, 2); head(0, w(0), 0, 0, 3);
        for (int i = 0; i < 5; i++) head(0, w(0), 0, 0, 4);
        head(1, w(4), 32'h4, 0, 3);
        head(1, w(8), 32'h8, 0, 2);
        head(1, w(12), 32'hC, 0, 2);
        head(1, w(16), 32'h10, 0, 2);
        head(0, w(16), 32'h10, 0, 3);
        head(0, w(16), 32'h10, 0, 4);
        head(0, w(16), 32'h10, 0, 4);
        // Redirect with full queue
        redir(32'h40, 0);
        idle(1); idle(1);
        head(1, w(32'h40), 32'h40, 0, 1);
        head(1, w(32'h44), 32'h44, 0, 1);
        // Run off the end of memory
        redir(32'hFFC, 1);
        idle(1); idle(1);
        head(1, w(32'hFFC), 32'hFFC, 0, 1);
        head(1, 32'h0, 32'h1000, 1, 1);
        idle(1); idle(1);
        // Misaligned fetch
        redir(32'h6, 1);
        idle(1); idle(1);
        head(1, 32'h0, 32'h6, 1, 1);
        idle(1);
        // Load port: plain load, read-first collision, out-of-range load
        add(0, 0, 0, 1, 1, 32'h20, 32'hDEADBEEF, 0, 0, 0, 0, 0);
        redir(32'h20, 1);
        idle(1);
        add(0, 0, 0, 1, 1, 32'h24, 32'h12345678, 0, 0, 0, 0, 0);
        head(1, 32'hDEADBEEF, 32'h20, 0, 1);
        head(1, w(32'h24), 32'h24, 0, 1);
        redir(32'h24, 1);
        idle(1); idle(1);
        head(1, 32'h12345678, 32'h24, 0, 1);
        add(0, 0, 0, 1, 1, 32'h1020, 32'h0BAD0BAD, 1, w(32'h28), 32'h28, 0, 1);
        redir(32'h20, 1);
        idle(1); idle(1);
        head(1, 32'hDEADBEEF, 32'h20, 0, 1);

        // Preload memory under reset
        rst = 1;
        for (int a = 0; a < 32'h60; a += 4) begin
            bus.ld_en = 1; bus.ld_addr = a; bus.ld_data = w(a);
            tick();
        end
        bus.ld_addr = 32'hFF8; bus.ld_data = w(32'hFF8); tick();
        bus.ld_addr = 32'hFFC; bus.ld_data = w(32'hFFC); tick();
        bus.ld_en = 0;

        for (int i = 0; i < tbl.size(); i++) begin
            rst = tbl[i].r;
            bus.redirect_valid = tbl[i].rv; bus.redirect_pc = tbl[i].rpc;
            bus.deq_ready = tbl[i].dq;
            bus.ld_en = tbl[i].le; bus.ld_addr = tbl[i].la; bus.ld_data = tbl[i].ldd;
            tick();
            chk($sformatf("row%0d", i), tbl[i].ev, tbl[i].ei, tbl[i].ep, tbl[i].ef, tbl[i].ec);
        end
        bus.redirect_valid = 0; bus.ld_en = 0;

        // Asynchronous reset mid-stream with count = 3
        bus.redirect_valid = 1; bus.redirect_pc = 0; bus.deq_ready = 0;
        tick();
        bus.redirect_valid = 0;
        for (int i = 0; i < 5; i++) tick();
        chk("pre_rst_cnt3", 1, w(0), 32'h0, 0, 3);
        #2 rst = 1;
        #1 chk("async_rst", 0, 0, 0, 0, 0);
        tick();
        rst = 0; bus.deq_ready = 1;
        for (int i = 0; i < 3; i++) tick();
        chk("restart_pc0", 1, w(0), 32'h0, 0, 1);
        for (int i = 0; i < 8; i++) tick();
        chk("mem_kept", 1, 32'hDEADBEEF, 32'h20, 0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end
endmodule
